// File: rtl/axi_lite_mem_master_if.sv
// AXI4-Lite master-side bundle used by axi_lite_mem_master.
// The master modport drives AW/W/AR and the B/R readies; the slave modport mirrors it.
interface axi_lite_mem_master_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   m_awaddr;
    logic [2:0]          m_awprot;
    logic                m_awvalid;
    logic                m_awready;
    logic [DATA_W-1:0]   m_wdata;
    logic [DATA_W/8-1:0] m_wstrb;
    logic                m_wvalid;
    logic                m_wready;
    logic [1:0]          m_bresp;
    logic                m_bvalid;
    logic                m_bready;
    logic [ADDR_W-1:0]   m_araddr;
    logic [2:0]          m_arprot;
    logic                m_arvalid;
    logic                m_arready;
    logic [DATA_W-1:0]   m_rdata;
    logic [1:0]          m_rresp;
    logic                m_rvalid;
    logic                m_rready;

    modport master (
        output m_awaddr, m_awprot, m_awvalid, input m_awready,
        output m_wdata, m_wstrb, m_wvalid, input m_wready,
        input m_bresp, m_bvalid, output m_bready,
        output m_araddr, m_arprot, m_arvalid, input m_arready,
        input m_rdata, m_rresp, m_rvalid, output m_rready
    );

    modport slave (
        input m_awaddr, m_awprot, m_awvalid, output m_awready,
        input m_wdata, m_wstrb, m_wvalid, output m_wready,
        output m_bresp, m_bvalid, input m_bready,
        input m_araddr, m_arprot, m_arvalid, output m_arready,
        output m_rdata, m_rresp, m_rvalid, input m_rready
    );
endinterface

// File: rtl/axi_lite_mem_master.sv
// Single-outstanding bridge from a req/done CPU memory port to an AXI4-Lite master.
// Define AXI_TIMEOUT_EN to add a watchdog that aborts a hung transaction with err=1.
module axi_lite_mem_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [3:0]        wstrb,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    axi_lite_mem_master_if.master bus
);

    typedef enum logic [2:0] {IDLE, WR_AW_W, WR_B, RD_AR, RD_R} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wstrb_q;
    logic              aw_done_q, w_done_q;
    logic              accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, timeout;

    assign accept = (state_q == IDLE) && req;
    assign aw_hs  = bus.m_awvalid && bus.m_awready;
    assign w_hs   = bus.m_wvalid  && bus.m_wready;
    assign b_hs   = bus.m_bvalid  && bus.m_bready;
    assign ar_hs  = bus.m_arvalid && bus.m_arready;
    assign r_hs   = bus.m_rvalid  && bus.m_rready;

`ifdef AXI_TIMEOUT_EN
    localparam int WD_W    = $clog2(TIMEOUT_CYCLES);
    localparam int WD_LAST = TIMEOUT_CYCLES - 2;
    logic [WD_W-1:0] wd_q;

    // Trips on the edge where the count would reach TIMEOUT_CYCLES-1.
    assign timeout = (state_q != IDLE) && (wd_q == WD_W'(WD_LAST));

    always_ff @(posedge clk) begin
        if (rst || accept) wd_q <= '0;
        else if (state_q != IDLE) wd_q <= wd_q + 1'b1;
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    logic unused_resp_lsb;
    assign unused_resp_lsb = bus.m_bresp[0] ^ bus.m_rresp[0];

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (req) state_d = we ? WR_AW_W : RD_AR;
            WR_AW_W: if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = WR_B;
            WR_B:    if (bus.m_bvalid) state_d = IDLE;
            RD_AR:   if (bus.m_arready) state_d = RD_R;
            RD_R:    if (bus.m_rvalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (timeout) state_d = IDLE;
    end

    // NOTE: valids/readies are decoded from registered state and flags only, so they
    // change solely on clock edges and never depend on the slave's ready inputs.
    always_comb begin
        busy           = (state_q != IDLE);
        bus.m_awvalid  = (state_q == WR_AW_W) && !aw_done_q;
        bus.m_wvalid   = (state_q == WR_AW_W) && !w_done_q;
        bus.m_bready   = (state_q == WR_B);
        bus.m_arvalid  = (state_q == RD_AR);
        bus.m_rready   = (state_q == RD_R);
        bus.m_awaddr   = addr_q;
        bus.m_araddr   = addr_q;
        bus.m_wdata    = wdata_q;
        bus.m_wstrb    = wstrb_q;
        bus.m_awprot   = 3'b000;
        bus.m_arprot   = 3'b000;
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch, not the sensitivity list.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                addr_q    <= addr;
                wdata_q   <= wdata;
                wstrb_q   <= wstrb;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
            if (b_hs) begin
                done <= 1'b1;
                err  <= bus.m_bresp[1];
            end
            if (r_hs) begin
                done <= 1'b1;
                err  <= bus.m_rresp[1];
                if (!bus.m_rresp[1]) rdata <= bus.m_rdata;
            end
            if (timeout) begin
                done <= 1'b1;
                err  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_master.sv
// Directed bench for axi_lite_mem_master; the slave side is driven by hand step by step.
// With AXI_TIMEOUT_EN defined it also exercises the watchdog at TIMEOUT_CYCLES=16.
module tb_axi_lite_mem_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        busy, done, err;
    logic [31:0] rdata;
    int          errors = 0;
    int          checks = 0;

    axi_lite_mem_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    axi_lite_mem_master #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .busy(busy), .done(done), .rdata(rdata), .err(err), .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
    endtask

    task automatic check_bus_idle(input string tag);
        check({tag, " awvalid"}, bus.m_awvalid, 1'b0);
        check({tag, " wvalid"},  bus.m_wvalid,  1'b0);
        check({tag, " bready"},  bus.m_bready,  1'b0);
        check({tag, " arvalid"}, bus.m_arvalid, 1'b0);
        check({tag, " rready"},  bus.m_rready,  1'b0);
        check({tag, " busy"},    busy, 1'b0);
        check({tag, " done"},    done, 1'b0);
    endtask

    initial begin
        bus.m_awready = 1'b0; bus.m_wready = 1'b0; bus.m_arready = 1'b0;
        bus.m_bvalid = 1'b0; bus.m_bresp = 2'b00;
        bus.m_rvalid = 1'b0; bus.m_rresp = 2'b00; bus.m_rdata = '0;

        // Reset state
        tick(); tick();
        check_bus_idle("reset");
        check("reset err", err, 1'b0);
        check("reset rdata", rdata, 32'h0);
        check("reset prot", {bus.m_awprot, bus.m_arprot}, 6'b0);
        rst = 1'b0;
        tick();

        // Write, always-ready slave
        bus.m_awready = 1'b1; bus.m_wready = 1'b1;
        issue(1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        check("wr c0 busy", busy, 1'b0);
        tick(); req = 1'b0;
        check("wr c1 awvalid", bus.m_awvalid, 1'b1);
        check("wr c1 wvalid", bus.m_wvalid, 1'b1);
        check("wr c1 awaddr", bus.m_awaddr, 32'h10);
        check("wr c1 wdata", bus.m_wdata, 32'hDEADBEEF);
        check("wr c1 wstrb", bus.m_wstrb, 4'hF);
        check("wr c1 busy", busy, 1'b1);
        tick();
        check("wr c2 awvalid", bus.m_awvalid, 1'b0);
        check("wr c2 wvalid", bus.m_wvalid, 1'b0);
        check("wr c2 bready", bus.m_bready, 1'b1);
        check("wr c2 busy", busy, 1'b1);
        tick();
        bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
        check("wr c3 busy", busy, 1'b1);
        check("wr c3 done", done, 1'b0);
        tick(); bus.m_bvalid = 1'b0;
        check("wr c4 done", done, 1'b1);
        check("wr c4 err", err, 1'b0);
        check("wr c4 busy", busy, 1'b0);
        check("wr c4 bready", bus.m_bready, 1'b0);
        tick();
        check("wr c5 done", done, 1'b0);

        // Read with arready delayed 3 cycles
        bus.m_arready = 1'b0;
        issue(1'b0, 32'h20, 32'h0, 4'h0);
        tick(); req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check("rd arvalid held", bus.m_arvalid, 1'b1);
            check("rd araddr stable", bus.m_araddr, 32'h20);
            tick();
        end
        bus.m_arready = 1'b1;
        check("rd c4 arvalid", bus.m_arvalid, 1'b1);
        tick(); bus.m_arready = 1'b0;
        check("rd c5 arvalid", bus.m_arvalid, 1'b0);
        check("rd c5 rready", bus.m_rready, 1'b1);
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'h12345678; bus.m_rresp = 2'b00;
        tick(); bus.m_rvalid = 1'b0;
        check("rd c6 done", done, 1'b1);
        check("rd c6 rdata", rdata, 32'h12345678);
        check("rd c6 err", err, 1'b0);
        check("rd c6 rready", bus.m_rready, 1'b0);
        tick();

        // Split write: wready in cycle 1, awready in cycle 4
        bus.m_awready = 1'b0; bus.m_wready = 1'b0;
        issue(1'b1, 32'h40, 32'hA5A50001, 4'h3);
        tick(); req = 1'b0;
        bus.m_wready = 1'b1;
        check("split c1 awvalid", bus.m_awvalid, 1'b1);
        check("split c1 wvalid", bus.m_wvalid, 1'b1);
        tick(); bus.m_wready = 1'b0;
        check("split c2 wvalid", bus.m_wvalid, 1'b0);
        check("split c2 awvalid", bus.m_awvalid, 1'b1);
        check("split c2 bready", bus.m_bready, 1'b0);
        tick();
        check("split c3 bready", bus.m_bready, 1'b0);
        tick(); bus.m_awready = 1'b1;
        check("split c4 awvalid", bus.m_awvalid, 1'b1);
        check("split c4 awaddr", bus.m_awaddr, 32'h40);
        tick(); bus.m_awready = 1'b0;
        check("split c5 awvalid", bus.m_awvalid, 1'b0);
        check("split c5 bready", bus.m_bready, 1'b1);
        check("split c5 done", done, 1'b0);
        bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
        tick(); bus.m_bvalid = 1'b0;
        check("split c6 done", done, 1'b1);
        check("split c6 err", err, 1'b0);
        tick();
        check("split c7 single done", done, 1'b0);

        // Error read, then back-to-back write accepted in the done cycle
        bus.m_arready = 1'b1;
        issue(1'b0, 32'h80, 32'h0, 4'h0);
        tick(); req = 1'b0;
        check("err c1 araddr", bus.m_araddr, 32'h80);
        tick();
        check("err c2 rready", bus.m_rready, 1'b1);
        bus.m_rvalid = 1'b1; bus.m_rdata = 32'hCAFEF00D; bus.m_rresp = 2'b10;
        tick(); bus.m_rvalid = 1'b0; bus.m_rresp = 2'b00;
        check("err c3 done", done, 1'b1);
        check("err c3 err", err, 1'b1);
        check("err c3 rdata kept", rdata, 32'h12345678);
        bus.m_arready = 1'b0; bus.m_awready = 1'b1; bus.m_wready = 1'b1;
        issue(1'b1, 32'h84, 32'h0BADCAFE, 4'hF);
        tick(); req = 1'b0;
        check("b2b c4 awvalid", bus.m_awvalid, 1'b1);
        check("b2b c4 err holds", err, 1'b1);
        check("b2b c4 done", done, 1'b0);
        tick();
        check("b2b c5 bready", bus.m_bready, 1'b1);
        bus.m_bvalid = 1'b1; bus.m_bresp = 2'b00;
        tick(); bus.m_bvalid = 1'b0;
        check("b2b c6 done", done, 1'b1);
        check("b2b c6 err", err, 1'b0);
        check("b2b c6 rdata", rdata, 32'h12345678);
        tick();

`ifdef AXI_TIMEOUT_EN
        // Slave never raises arready
        bus.m_arready = 1'b0;
        issue(1'b0, 32'h300, 32'h0, 4'h0);
        tick(); req = 1'b0;
        check("to c1 arvalid", bus.m_arvalid, 1'b1);
        repeat (14) tick();
        check("to c15 done", done, 1'b0);
        check("to c15 arvalid", bus.m_arvalid, 1'b1);
        tick();
        check("to c16 done", done, 1'b1);
        check("to c16 err", err, 1'b1);
        check("to c16 arvalid", bus.m_arvalid, 1'b0);
        check("to c16 busy", busy, 1'b0);
        check("to c16 rdata", rdata, 32'h12345678);
        issue(1'b1, 32'h304, 32'h55AA55AA, 4'hF);
        tick(); req = 1'b0;
        check("to c17 awvalid", bus.m_awvalid, 1'b1);
        tick();
        check("to c18 bready", bus.m_bready, 1'b1);
        bus.m_bvalid = 1'b1;
        tick(); bus.m_bvalid = 1'b0;
        check("to c19 done", done, 1'b1);
        check("to c19 err", err, 1'b0);
        tick();
`endif

        // Request while busy is ignored; reset in WR_B aborts
        bus.m_awready = 1'b1; bus.m_wready = 1'b1;
        issue(1'b1, 32'h100, 32'h11, 4'hF);
        tick();
        issue(1'b0, 32'h200, 32'h0, 4'h0);
        check("ign c1 awvalid", bus.m_awvalid, 1'b1);
        tick(); req = 1'b0;
        check("ign c2 bready", bus.m_bready, 1'b1);
        check("ign c2 arvalid", bus.m_arvalid, 1'b0);
        rst = 1'b1;
        tick(); rst = 1'b0;
        check_bus_idle("rst");
        tick();
        check("rst c4 no queued read", bus.m_arvalid, 1'b0);
        bus.m_bvalid = 1'b1;
        tick();
        check("stray bvalid bready", bus.m_bready, 1'b0);
        check("stray bvalid done", done, 1'b0);
        bus.m_bvalid = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axi_lite_mem_master.md
Name: axi_lite_mem_master

Overview:
- Bridges the CPU's simple single-beat memory port (addr / wdata / write-enable / rdata) to an AXI4-Lite master interface.
- Lets the core reach AXI4-Lite slaves (AXI-wrapped instruction/data memories, peripherals) instead of directly wired BRAMs.
- One outstanding transaction at a time; the CPU side sees a request pulse in and a done pulse out.

Parameters:
- ADDR_W, 32, AXI and CPU-side byte-address width
- DATA_W, 32, data width; fixed at 32 (WSTRB is 4 bits)
- TIMEOUT_CYCLES, 1024, watchdog limit; used only when AXI_TIMEOUT_EN is defined

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  1  single-cycle request pulse; sampled only in IDLE
- we  in  1  1 = write, 0 = read; sampled with req
- addr  in  ADDR_W  byte address; passed to AWADDR/ARADDR unmodified
- wdata  in  DATA_W  write data, sampled with req
- wstrb  in  4  byte enables, sampled with req
- busy  out  1  high from the cycle after req is accepted until done
- done  out  1  one-cycle pulse on transaction completion
- rdata  out  DATA_W  read data; holds last completed read
- err  out  1  valid with done; 1 = SLVERR/DECERR (resp[1]) or timeout
- m_awaddr, m_awvalid (out); m_awready (in)
- m_wdata, m_wstrb, m_wvalid (out); m_wready (in)
- m_bresp[1:0], m_bvalid (in); m_bready (out)
- m_araddr, m_arvalid (out); m_arready (in)
- m_rdata, m_rresp[1:0], m_rvalid (in); m_rready (out)
- m_awprot, m_arprot  out  3  tied to 3'b000

Behaviour:
- Reset values:
  - state IDLE.
  - All valid/ready outputs, busy, done and err are 0.
  - rdata, the latched addr/wdata/wstrb and the watchdog are 0.
- FSM states: IDLE, WR_AW_W, WR_B, RD_AR, RD_R.
- IDLE:
  - On req, latch we/addr/wdata/wstrb.
  - If we, go to WR_AW_W and assert m_awvalid and m_wvalid (registered, visible the next cycle).
  - Otherwise go to RD_AR and assert m_arvalid.
  - busy rises in the same cycle.
- WR_AW_W:
  - AW and W complete independently; each valid drops the cycle after its own valid&ready handshake.
  - AWADDR/WDATA/WSTRB stay stable while their valid is high.
  - Once both handshakes have happened (same or different cycles), go to WR_B with m_bready=1.
- WR_B:
  - On m_bvalid: m_bready drops, err<=m_bresp[1], done<=1 for one cycle, busy<=0, return to IDLE.
- RD_AR:
  - m_arvalid held until m_arready, then dropped; go to RD_R with m_rready=1.
- RD_R:
  - On m_rvalid: rdata<=m_rdata, err<=m_rresp[1], m_rready drops, done pulse, busy<=0, return to IDLE.
- Minimum latency with always-ready slaves that respond one cycle after the handshake:
  - req in cycle 0 → valid in cycle 1 → bready/rready in cycle 2 → response in cycle 3 → done in cycle 4.
- req outside IDLE is ignored; no queuing.
- done is high in the first IDLE cycle. A req in that same cycle is accepted, so back-to-back transactions are allowed.
- err holds its value until the next done. rdata is unchanged by writes and by errored reads (rdata is not updated when resp[1]=1).
- Reset mid-transaction:
  - The FSM returns to IDLE and all valids/readies drop on the reset edge.
  - The attached slave is reset on the same rst; no transaction is resumed.
- An unexpected m_bvalid/m_rvalid in the wrong state is not acknowledged (ready stays 0).

Optional Feature:
- Macro: AXI_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on req acceptance and counts every cycle in a non-IDLE state.
  - If it reaches TIMEOUT_CYCLES-1 without completion, the FSM drops all valids/readies, returns to IDLE, pulses done with err=1, and leaves rdata unchanged.
- Not defined: no counter exists and a hung slave leaves busy high indefinitely.

Test Plan:
- Write, always-ready slave, bvalid one cycle after B ready:
  - Stimulus: req, we=1, addr=0x10, wdata=0xDEADBEEF, wstrb=0xF.
  - Required: AW and W handshake in the same cycle, bresp=00, done in cycle 4, err=0, busy high cycles 1-3.
- Read with staggered ready:
  - Stimulus: arready delayed 3 cycles; rvalid with m_rdata=0x12345678, rresp=00.
  - Required: araddr stable while arvalid is high; rdata=0x12345678, err=0.
- Split write handshake:
  - Stimulus: wready in cycle 1, awready in cycle 4.
  - Required: wvalid low from cycle 2; awvalid low from cycle 5; bready only after both; a single done.
- Error response:
  - Stimulus: read with rresp=2'b10.
  - Required: err=1, rdata keeps its previous value. Then a write with bresp=2'b00 gives err=0.
- Ignored request and reset mid-op:
  - Stimulus: req pulsed while busy, then rst in WR_B.
  - Required: the second req is ignored. After the reset edge, all m_*valid and m_*ready are 0, busy=0, done=0, and the FSM is in IDLE.
- AXI_TIMEOUT_EN with TIMEOUT_CYCLES=16, slave never raises arready:
  - Required: done with err=1 exactly 16 cycles after acceptance; arvalid deasserted; a new req is accepted.
